// File: rtl/systolic_sequencer.sv
// systolic_sequencer
//   Instruction sequencer for an ARR_SIZE x ARR_SIZE systolic MAC array.
//   It takes one 64-bit instruction at a time and turns it into registered
//   strobes for the input/weight buffers, the MAC array and the accumulator.
//
//   Instruction fields: [63:60] opcode, [59:45] addr, [44:41] tile,
//                       [40:32] len, [31:0] data
//   Opcodes: 0 NOP, 1 LD_INP, 2 LD_WT, 3 COMPUTE, 4 ACC_CLR, 5 READ_OUT,
//            6-15 illegal (sets the sticky err_illegal flag).
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   instr_valid, instr      instruction handshake input
//   instr_ready             high while IDLE (instruction accepted this cycle)
//   inp_buf_we/addr/data    input buffer write strobe, address, write data
//   wt_buf_we/addr/data     weight buffer write strobe, address, write data
//   mac_en                  MAC array advance enable
//   acc_reset               clear accumulator
//   acc_store, acc_op_addr  store accumulator into output buffer slot
//   op_buf_rd_en/rd_addr    output buffer read strobe and slot
//   busy                    FSM not in IDLE
//   err_illegal             sticky illegal-opcode flag
module systolic_sequencer #(
  parameter int ARR_SIZE  = 4,
  parameter int DRAIN_CYC = 2*ARR_SIZE-1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [63:0] instr,
  output logic        instr_ready,
  output logic        inp_buf_we,
  output logic [14:0] inp_buf_addr,
  output logic [31:0] inp_buf_data,
  output logic        wt_buf_we,
  output logic [14:0] wt_buf_addr,
  output logic [31:0] wt_buf_data,
  output logic        mac_en,
  output logic        acc_reset,
  output logic        acc_store,
  output logic [3:0]  acc_op_addr,
  output logic        op_buf_rd_en,
  output logic [3:0]  op_buf_rd_addr,
  output logic        busy,
  output logic        err_illegal
);

  localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'((DRAIN_CYC > 0) ? (DRAIN_CYC - 1) : 0);

  localparam logic [3:0] OP_NOP      = 4'd0;
  localparam logic [3:0] OP_LD_INP   = 4'd1;
  localparam logic [3:0] OP_LD_WT    = 4'd2;
  localparam logic [3:0] OP_COMPUTE  = 4'd3;
  localparam logic [3:0] OP_ACC_CLR  = 4'd4;
  localparam logic [3:0] OP_READ_OUT = 4'd5;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, STORE} state_t;

  state_t state, state_nxt;

  logic [3:0]  f_op;
  logic [14:0] f_addr;
  logic [3:0]  f_tile;
  logic [8:0]  f_len;
  logic [31:0] f_data;
  logic        accept;

  // Remaining MAC cycles after the current one, remaining drain cycles, tile of the running COMPUTE
  logic [8:0]     run_cnt, run_cnt_nxt;
  logic [DCW-1:0] drain_cnt, drain_cnt_nxt;
  logic [3:0]     tile_q, tile_nxt;

  logic        inp_buf_we_nxt, wt_buf_we_nxt, mac_en_nxt, acc_reset_nxt;
  logic        acc_store_nxt, op_buf_rd_en_nxt, err_illegal_nxt;
  logic [14:0] inp_buf_addr_nxt, wt_buf_addr_nxt;
  logic [31:0] inp_buf_data_nxt, wt_buf_data_nxt;
  logic [3:0]  acc_op_addr_nxt, op_buf_rd_addr_nxt;

  assign f_op   = instr[63:60];
  assign f_addr = instr[59:45];
  assign f_tile = instr[44:41];
  assign f_len  = instr[40:32];
  assign f_data = instr[31:0];

  assign instr_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign accept      = instr_valid & instr_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept && f_op == OP_COMPUTE && f_len != 9'd0) state_nxt = RUN;
      RUN:     if (run_cnt == 9'd0) state_nxt = (DRAIN_CYC == 0) ? STORE : DRAIN;
      DRAIN:   if (drain_cnt == '0) state_nxt = STORE;
      STORE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs; data/addresses hold unless updated
  always_comb begin
    inp_buf_we_nxt     = 1'b0;
    wt_buf_we_nxt      = 1'b0;
    mac_en_nxt         = 1'b0;
    acc_reset_nxt      = 1'b0;
    acc_store_nxt      = 1'b0;
    op_buf_rd_en_nxt   = 1'b0;
    err_illegal_nxt    = err_illegal;
    inp_buf_addr_nxt   = inp_buf_addr;
    wt_buf_addr_nxt    = wt_buf_addr;
    inp_buf_data_nxt   = inp_buf_data;
    wt_buf_data_nxt    = wt_buf_data;
    acc_op_addr_nxt    = acc_op_addr;
    op_buf_rd_addr_nxt = op_buf_rd_addr;
    run_cnt_nxt        = run_cnt;
    drain_cnt_nxt      = drain_cnt;
    tile_nxt           = tile_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          case (f_op)
            OP_NOP: ;
            OP_LD_INP: begin
              inp_buf_we_nxt   = 1'b1;
              inp_buf_addr_nxt = f_addr;
              inp_buf_data_nxt = f_data;
            end
            OP_LD_WT: begin
              wt_buf_we_nxt   = 1'b1;
              wt_buf_addr_nxt = f_addr;
              wt_buf_data_nxt = f_data;
            end
            OP_COMPUTE: begin
              // A zero-length COMPUTE is consumed without touching anything
              if (f_len != 9'd0) begin
                mac_en_nxt       = 1'b1;
                inp_buf_addr_nxt = f_addr;
                wt_buf_addr_nxt  = f_addr;
                run_cnt_nxt      = f_len - 9'd1;
                tile_nxt         = f_tile;
              end
            end
            OP_ACC_CLR:  acc_reset_nxt = 1'b1;
            OP_READ_OUT: begin
              op_buf_rd_en_nxt   = 1'b1;
              op_buf_rd_addr_nxt = f_tile;
            end
            default: err_illegal_nxt = 1'b1;
          endcase
        end
      end
      RUN: begin
        if (run_cnt != 9'd0) begin
          mac_en_nxt       = 1'b1;
          inp_buf_addr_nxt = inp_buf_addr + 15'd1;
          wt_buf_addr_nxt  = wt_buf_addr + 15'd1;
          run_cnt_nxt      = run_cnt - 9'd1;
        end else begin
          drain_cnt_nxt = DRAIN_LAST;
          if (DRAIN_CYC == 0) begin
            acc_store_nxt   = 1'b1;
            acc_op_addr_nxt = tile_q;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) begin
          acc_store_nxt   = 1'b1;
          acc_op_addr_nxt = tile_q;
        end else begin
          drain_cnt_nxt = drain_cnt - DCW'(1);
        end
      end
      STORE: ;
      default: ;
    endcase
  end

  // Output and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inp_buf_we     <= 1'b0;
      wt_buf_we      <= 1'b0;
      mac_en         <= 1'b0;
      acc_reset      <= 1'b0;
      acc_store      <= 1'b0;
      op_buf_rd_en   <= 1'b0;
      err_illegal    <= 1'b0;
      inp_buf_addr   <= '0;
      wt_buf_addr    <= '0;
      inp_buf_data   <= '0;
      wt_buf_data    <= '0;
      acc_op_addr    <= '0;
      op_buf_rd_addr <= '0;
      run_cnt        <= '0;
      drain_cnt      <= '0;
      tile_q         <= '0;
    end else begin
      inp_buf_we     <= inp_buf_we_nxt;
      wt_buf_we      <= wt_buf_we_nxt;
      mac_en         <= mac_en_nxt;
      acc_reset      <= acc_reset_nxt;
      acc_store      <= acc_store_nxt;
      op_buf_rd_en   <= op_buf_rd_en_nxt;
      err_illegal    <= err_illegal_nxt;
      inp_buf_addr   <= inp_buf_addr_nxt;
      wt_buf_addr    <= wt_buf_addr_nxt;
      inp_buf_data   <= inp_buf_data_nxt;
      wt_buf_data    <= wt_buf_data_nxt;
      acc_op_addr    <= acc_op_addr_nxt;
      op_buf_rd_addr <= op_buf_rd_addr_nxt;
      run_cnt        <= run_cnt_nxt;
      drain_cnt      <= drain_cnt_nxt;
      tile_q         <= tile_nxt;
    end
  end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed testbench for systolic_sequencer (ARR_SIZE=4, DRAIN_CYC=7).
module tb_systolic_sequencer;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [63:0] instr;
  logic        instr_ready;
  logic        inp_buf_we, wt_buf_we;
  logic [14:0] inp_buf_addr, wt_buf_addr;
  logic [31:0] inp_buf_data, wt_buf_data;
  logic        mac_en, acc_reset, acc_store;
  logic [3:0]  acc_op_addr;
  logic        op_buf_rd_en;
  logic [3:0]  op_buf_rd_addr;
  logic        busy, err_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  systolic_sequencer #(.ARR_SIZE(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready),
    .inp_buf_we(inp_buf_we), .inp_buf_addr(inp_buf_addr), .inp_buf_data(inp_buf_data),
    .wt_buf_we(wt_buf_we), .wt_buf_addr(wt_buf_addr), .wt_buf_data(wt_buf_data),
    .mac_en(mac_en), .acc_reset(acc_reset), .acc_store(acc_store), .acc_op_addr(acc_op_addr),
    .op_buf_rd_en(op_buf_rd_en), .op_buf_rd_addr(op_buf_rd_addr),
    .busy(busy), .err_illegal(err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] mk(input logic [3:0] op, input logic [14:0] a,
                                     input logic [3:0] t, input logic [8:0] l,
                                     input logic [31:0] d);
    return {op, a, t, l, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; instr_valid = 1'b0; instr = '0;
    #1 rst_n = 1'b0;
    #2;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", instr_ready); end
    n_checks++; if (mac_en !== 1'b0) begin n_fail++; $display("FAIL rst_mac_en: got %b expected 0", mac_en); end
    n_checks++; if (err_illegal !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", err_illegal); end
    n_checks++; if (inp_buf_addr !== 15'h0) begin n_fail++; $display("FAIL rst_inp_addr: got %h expected 0", inp_buf_addr); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b expected 1", instr_ready); end
  endtask

  task automatic test_loads();
    instr_valid = 1'b1; instr = mk(4'd1, 15'h0010, 4'd0, 9'd0, 32'hDEADBEEF);
    tick();
    n_checks++; if (inp_buf_we !== 1'b1) begin n_fail++; $display("FAIL ld_inp_we: got %b expected 1", inp_buf_we); end
    n_checks++; if (inp_buf_addr !== 15'h0010) begin n_fail++; $display("FAIL ld_inp_addr: got %h expected 0010", inp_buf_addr); end
    n_checks++; if (inp_buf_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ld_inp_data: got %h expected deadbeef", inp_buf_data); end
    n_checks++; if (wt_buf_we !== 1'b0) begin n_fail++; $display("FAIL ld_inp_wt_we: got %b expected 0", wt_buf_we); end
    n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL ld_ready1: got %b expected 1", instr_ready); end
    instr = mk(4'd2, 15'h0011, 4'd0, 9'd0, 32'h12345678);
    tick();
    n_checks++; if (wt_buf_we !== 1'b1) begin n_fail++; $display("FAIL ld_wt_we: got %b expected 1", wt_buf_we); end
    n_checks++; if (wt_buf_addr !== 15'h0011) begin n_fail++; $display("FAIL ld_wt_addr: got %h expected 0011", wt_buf_addr); end
    n_checks++; if (wt_buf_data !== 32'h12345678) begin n_fail++; $display("FAIL ld_wt_data: got %h expected 12345678", wt_buf_data); end
    n_checks++; if (inp_buf_we !== 1'b0) begin n_fail++; $display("FAIL ld_wt_inp_we: got %b expected 0", inp_buf_we); end
    n_checks++; if (inp_buf_addr !== 15'h0010) begin n_fail++; $display("FAIL ld_inp_addr_hold: got %h expected 0010", inp_buf_addr); end
    n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL ld_ready2: got %b expected 1", instr_ready); end
    instr_valid = 1'b0;
    tick();
    n_checks++; if (wt_buf_we !== 1'b0) begin n_fail++; $display("FAIL ld_wt_we_end: got %b expected 0", wt_buf_we); end
    n_checks++; if (wt_buf_data !== 32'h12345678) begin n_fail++; $display("FAIL ld_wt_data_hold: got %h expected 12345678", wt_buf_data); end
  endtask

  task automatic test_compute();
    logic [14:0] ea;
    instr_valid = 1'b1; instr = mk(4'd3, 15'h7FFE, 4'd3, 9'd4, 32'h0);
    tick();
    instr_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) tick();
      ea = (c <= 4) ? (15'h7FFE + 15'(c - 1)) : 15'h0001;
      n_checks++; if (instr_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL cmp_busy c=%0d: got ready=%b busy=%b expected 0/1", c, instr_ready, busy); end
      n_checks++; if (mac_en !== (c <= 4)) begin n_fail++; $display("FAIL cmp_mac_en c=%0d: got %b expected %b", c, mac_en, (c <= 4)); end
      n_checks++; if (inp_buf_addr !== ea || wt_buf_addr !== ea) begin n_fail++; $display("FAIL cmp_addr c=%0d: got %h/%h expected %h", c, inp_buf_addr, wt_buf_addr, ea); end
      n_checks++; if (acc_store !== (c == 12)) begin n_fail++; $display("FAIL cmp_store c=%0d: got %b expected %b", c, acc_store, (c == 12)); end
      n_checks++; if (inp_buf_we !== 1'b0 || wt_buf_we !== 1'b0) begin n_fail++; $display("FAIL cmp_we c=%0d: got %b/%b expected 0/0", c, inp_buf_we, wt_buf_we); end
    end
    n_checks++; if (acc_op_addr !== 4'd3) begin n_fail++; $display("FAIL cmp_op_addr: got %0d expected 3", acc_op_addr); end
    tick();
    n_checks++; if (instr_ready !== 1'b1 || busy !== 1'b0 || acc_store !== 1'b0) begin n_fail++; $display("FAIL cmp_done: got ready=%b busy=%b store=%b expected 1/0/0", instr_ready, busy, acc_store); end
  endtask

  task automatic test_len0_readout();
    instr_valid = 1'b1; instr = mk(4'd3, 15'h0100, 4'd2, 9'd0, 32'h0);
    tick();
    n_checks++; if (mac_en !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL len0_idle: got mac=%b busy=%b expected 0/0", mac_en, busy); end
    n_checks++; if (inp_buf_addr !== 15'h0001) begin n_fail++; $display("FAIL len0_addr_hold: got %h expected 0001", inp_buf_addr); end
    n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL len0_ready: got %b expected 1", instr_ready); end
    instr = mk(4'd5, 15'h0, 4'd9, 9'd0, 32'h0);
    tick();
    n_checks++; if (op_buf_rd_en !== 1'b1 || op_buf_rd_addr !== 4'd9) begin n_fail++; $display("FAIL rd_pulse: got en=%b addr=%0d expected 1/9", op_buf_rd_en, op_buf_rd_addr); end
    n_checks++; if (mac_en !== 1'b0 || acc_store !== 1'b0) begin n_fail++; $display("FAIL rd_no_mac: got mac=%b store=%b expected 0/0", mac_en, acc_store); end
    instr = mk(4'd0, 15'h1234, 4'd7, 9'd5, 32'hCAFEF00D);
    tick();
    n_checks++; if (op_buf_rd_en !== 1'b0 || op_buf_rd_addr !== 4'd9) begin n_fail++; $display("FAIL nop_rd: got en=%b addr=%0d expected 0/9", op_buf_rd_en, op_buf_rd_addr); end
    n_checks++; if (inp_buf_we !== 1'b0 || mac_en !== 1'b0 || busy !== 1'b0 || inp_buf_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL nop_quiet: got we=%b mac=%b busy=%b data=%h expected 0/0/0/deadbeef", inp_buf_we, mac_en, busy, inp_buf_data); end
    instr_valid = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    instr_valid = 1'b1; instr = mk(4'hA, 15'h0555, 4'd1, 9'd3, 32'hAAAA5555);
    tick();
    n_checks++; if (err_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_err: got %b expected 1", err_illegal); end
    n_checks++; if (inp_buf_we | wt_buf_we | mac_en | acc_reset | op_buf_rd_en | busy) begin n_fail++; $display("FAIL ill_quiet: got strobes %b%b%b%b%b busy=%b expected all 0", inp_buf_we, wt_buf_we, mac_en, acc_reset, op_buf_rd_en, busy); end
    n_checks++; if (inp_buf_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ill_data_hold: got %h expected deadbeef", inp_buf_data); end
    instr = mk(4'd4, 15'h0, 4'd0, 9'd0, 32'h0);
    tick();
    n_checks++; if (acc_reset !== 1'b1 || err_illegal !== 1'b1) begin n_fail++; $display("FAIL clr_pulse: got rst=%b err=%b expected 1/1", acc_reset, err_illegal); end
    instr_valid = 1'b0;
    tick();
    n_checks++; if (acc_reset !== 1'b0 || err_illegal !== 1'b1) begin n_fail++; $display("FAIL clr_end: got rst=%b err=%b expected 0/1", acc_reset, err_illegal); end
  endtask

  task automatic test_reset_in_drain();
    logic saw;
    instr_valid = 1'b1; instr = mk(4'd3, 15'h0020, 4'd5, 9'd8, 32'h0);
    tick();
    instr_valid = 1'b0;
    repeat (9) tick();
    n_checks++; if (busy !== 1'b1 || mac_en !== 1'b0) begin n_fail++; $display("FAIL drain_state: got busy=%b mac=%b expected 1/0", busy, mac_en); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || instr_ready !== 1'b1 || err_illegal !== 1'b0) begin n_fail++; $display("FAIL arst_ctrl: got busy=%b ready=%b err=%b expected 0/1/0", busy, instr_ready, err_illegal); end
    n_checks++; if (inp_buf_addr !== 15'h0 || wt_buf_addr !== 15'h0 || inp_buf_data !== 32'h0 || acc_op_addr !== 4'h0) begin n_fail++; $display("FAIL arst_data: got %h %h %h %h expected all 0", inp_buf_addr, wt_buf_addr, inp_buf_data, acc_op_addr); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    n_checks++; if (instr_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL arst_release: got ready=%b busy=%b expected 1/0", instr_ready, busy); end
    saw = 1'b0;
    repeat (20) begin
      tick();
      if (acc_store !== 1'b0 || busy !== 1'b0) saw = 1'b1;
    end
    n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL arst_abandon: got store/busy activity=%b expected 0", saw); end
  endtask

  task automatic test_back_to_back();
    instr_valid = 1'b1; instr = mk(4'd3, 15'h0200, 4'd1, 9'd2, 32'h0);
    tick();
    instr = mk(4'd3, 15'h0300, 4'd6, 9'd3, 32'h0);
    n_checks++; if (inp_buf_addr !== 15'h0200 || instr_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_a1: got addr=%h ready=%b expected 0200/0", inp_buf_addr, instr_ready); end
    for (int c = 2; c <= 10; c++) begin
      tick();
      if (c == 2) begin
        n_checks++; if (inp_buf_addr !== 15'h0201 || mac_en !== 1'b1) begin n_fail++; $display("FAIL b2b_a2: got addr=%h mac=%b expected 0201/1", inp_buf_addr, mac_en); end
      end
      if (c == 10) begin
        n_checks++; if (acc_store !== 1'b1 || acc_op_addr !== 4'd1) begin n_fail++; $display("FAIL b2b_a_store: got store=%b slot=%0d expected 1/1", acc_store, acc_op_addr); end
      end
    end
    tick();
    n_checks++; if (instr_ready !== 1'b1 || busy !== 1'b0 || mac_en !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got ready=%b busy=%b mac=%b expected 1/0/0", instr_ready, busy, mac_en); end
    tick();
    instr_valid = 1'b0;
    n_checks++; if (mac_en !== 1'b1 || inp_buf_addr !== 15'h0300 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_b1: got mac=%b addr=%h busy=%b expected 1/0300/1", mac_en, inp_buf_addr, busy); end
    for (int c = 13; c <= 22; c++) begin
      tick();
      if (c == 14) begin
        n_checks++; if (wt_buf_addr !== 15'h0302) begin n_fail++; $display("FAIL b2b_b_addr: got %h expected 0302", wt_buf_addr); end
      end
      if (c == 22) begin
        n_checks++; if (acc_store !== 1'b1 || acc_op_addr !== 4'd6) begin n_fail++; $display("FAIL b2b_b_store: got store=%b slot=%0d expected 1/6", acc_store, acc_op_addr); end
      end
    end
    tick();
    n_checks++; if (busy !== 1'b0 || acc_store !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got busy=%b store=%b expected 0/0", busy, acc_store); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_compute();
    test_len0_readout();
    test_illegal();
    test_reset_in_drain();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_sequencer.md
SYSTOLIC_SEQUENCER -- requirements
Module: systolic_sequencer

Interface
REQ-001 Parameter ARR_SIZE, default 4, systolic array dimension (PEs per side); SHALL be 2..16.
REQ-002 Parameter DRAIN_CYC, default 2*ARR_SIZE-1, cycles to flush the array after the last MAC enable.
REQ-003 clk  in  1  single clock; all state SHALL be updated on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 instr_valid  in  1  instruction buffer holds a valid instruction.
REQ-006 instr  in  64  instruction word, fields [63:60] opcode, [59:45] addr, [44:41] tile, [40:32] len, [31:0] data.
REQ-007 instr_ready  out  1  sequencer accepts instr this cycle.
REQ-008 inp_buf_we / wt_buf_we  out  1 each  write strobe to input / weight buffer.
REQ-009 inp_buf_addr / wt_buf_addr  out  15 each  buffer address, write or read.
REQ-010 inp_buf_data / wt_buf_data  out  32 each  buffer write data.
REQ-011 mac_en  out  1  MAC array advance enable.
REQ-012 acc_reset  out  1  clear accumulator.
REQ-013 acc_store  out  1  accumulator writes result to output buffer.
REQ-014 acc_op_addr  out  4  output buffer slot for acc_store.
REQ-015 op_buf_rd_en  out  1  output buffer drives slot op_buf_rd_addr to external port.
REQ-016 op_buf_rd_addr  out  4  output buffer read slot.
REQ-017 busy  out  1  FSM not in IDLE.
REQ-018 err_illegal  out  1  sticky illegal-opcode flag.

Function
REQ-019 FSM states SHALL be IDLE, RUN, DRAIN, STORE; instr_ready SHALL equal (state==IDLE).
REQ-020 Accept = instr_valid & instr_ready; all strobes SHALL be registered, asserted exactly one cycle after the accept edge.
REQ-021 Opcode 0 NOP: accepted, no output activity.
REQ-022 Opcode 1 LD_INP: inp_buf_we=1 for one cycle with inp_buf_addr=addr, inp_buf_data=data; FSM stays IDLE, so back-to-back loads sustain one per cycle.
REQ-023 Opcode 2 LD_WT: same as LD_INP on the wt_buf_* ports.
REQ-024 Opcode 3 COMPUTE, len>0: IDLE->RUN; mac_en=1 for exactly len consecutive cycles, inp_buf_addr=wt_buf_addr=addr+i (i=0..len-1, modulo 2^15 wrap), we strobes low.
REQ-025 RUN->DRAIN after the len-th cycle; mac_en=0 for exactly DRAIN_CYC cycles.
REQ-026 DRAIN->STORE; acc_store=1, acc_op_addr=tile latched at accept, for one cycle; STORE->IDLE next cycle.
REQ-027 COMPUTE with len=0 SHALL behave as NOP (no mac_en, no acc_store, FSM stays IDLE).
REQ-028 Opcode 4 ACC_CLR: acc_reset=1 for one cycle; FSM stays IDLE.
REQ-029 Opcode 5 READ_OUT: op_buf_rd_en=1, op_buf_rd_addr=tile, for one cycle; FSM stays IDLE.
REQ-030 Opcodes 6-15: instruction consumed, no strobes, err_illegal set to 1 and held until reset.
REQ-031 Latched addr, tile, len SHALL be stable across a COMPUTE; changes on instr while busy SHALL have no effect.
REQ-032 Total COMPUTE occupancy SHALL be len+DRAIN_CYC+1 cycles of instr_ready=0.
REQ-033 When not being strobed, data/address outputs SHALL hold their last values; strobes SHALL be 0.

Reset
REQ-034 rst_n=0 SHALL immediately force state IDLE, all strobes, mac_en, busy and err_illegal to 0, addresses, data and counters to 0, regardless of state.
REQ-035 A COMPUTE interrupted by reset SHALL be abandoned: no acc_store after rst_n returns high.
REQ-036 instr_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification
REQ-037 LD_INP addr=0x0010 data=0xDEADBEEF, then LD_WT addr=0x0011 data=0x12345678 on consecutive cycles -> one we pulse each, correct address/data, instr_ready never drops.
REQ-038 COMPUTE addr=0x7FFE len=4 tile=3, ARR_SIZE=4 -> mac_en high 4 cycles with addresses 0x7FFE,0x7FFF,0x0000,0x0001, 7 drain cycles, acc_store with acc_op_addr=3, busy/not-ready for 12 cycles.
REQ-039 COMPUTE len=0 followed by READ_OUT tile=9 -> no mac_en, op_buf_rd_en pulse with addr 9 two cycles after the first accept.
REQ-040 Opcode 0xA then ACC_CLR -> err_illegal=1 and stays 1; acc_reset pulse occurs normally.
REQ-041 rst_n pulled low during DRAIN of COMPUTE len=8 -> outputs 0 asynchronously, no acc_store afterwards, instr_ready=1 first cycle after release.
REQ-042 instr_valid held high with a second COMPUTE during a busy COMPUTE -> second accepted only on return to IDLE, its fields used, not the first's.
